dec_accum: RTL and testbench
============================

// Module: dec_accum
// PURPOSE
// - Streaming decimal-to-binary accumulator; the inverse of the binary-to-decimal digit selector.
// - Consumes one decimal digit per handshake, most significant digit first, e.g. a parsed GPS speed field.
// - Emits the integer part as an unsigned binary value for the speedometer datapath.
// - Handles an optional decimal point, overflow saturation and invalid digits.
// PARAMETERS
// - WIDTH_P  8  width of value_o in bits; saturation limit is 2**WIDTH_P-1
// PORTS
// - clk_i      in   1        single clock domain; all logic on posedge
// - reset_i    in   1        synchronous, active-high reset
// - digit_i    in   4        digit 0..9 on digit beats; ignored on point/last beats
// - point_i    in   1        beat is a decimal point (no digit)
// - last_i     in   1        beat is the field terminator (no digit)
// - valid_i    in   1        input beat valid
// - ready_o    out  1        block can accept a beat
// - value_o    out  WIDTH_P  accumulated integer value; stable while valid_o=1
// - ovf_o      out  1        value saturated during this field
// - err_o      out  1        invalid digit or second point seen during this field
// - valid_o    out  1        result available
// - ready_i    in   1        downstream accepts result
// BEHAVIOUR
// - Reset: state=ACC; accumulator=0, ovf=0, err=0, round flag=0.
// - Reset outputs: value_o=0, ovf_o=0, err_o=0, valid_o=0, ready_o=1.
// - Reset mid-field or mid-DONE discards everything; there is no partial output.
// - Beat accepted when valid_i & ready_o. ready_o=1 in ACC and FRAC; ready_o=0 in DONE.
// - Beat priority: last_i > point_i > digit. Only one action is taken per beat.
// - State ACC, digit d<=9: acc <= acc*10+d.
//   - Computed at WIDTH_P+4 bits; if result > 2**WIDTH_P-1, acc <= all-ones and ovf <= 1.
//   - Once ovf=1, acc stays all-ones for the rest of the field.
// - Any state, digit >9: err <= 1; digit discarded; state unchanged.
// - ACC + point: go to FRAC; acc unchanged.
// - FRAC + point: err <= 1; stay in FRAC.
// - FRAC + digit: accepted and never added to the integer part (see CONFIGURATION).
// - ACC/FRAC + last: go to DONE.
//   - Empty field (terminator only) gives value 0, no flags.
//   - point and last on the same beat: treated as last only.
// - DONE: valid_o=1; value_o, ovf_o and err_o hold the field result.
//   - All three stay stable until valid_o & ready_i.
// - Latency: last accepted at cycle N gives valid_o=1 at N+1.
// - On valid_o & ready_i at cycle M: go to ACC and clear acc and flags. valid_o=0 and ready_o=1 at M+1.
// - Input beats are never accepted in DONE; there is no overlap between fields.
// - value_o, ovf_o and err_o are registered; value_o always shows acc. It is meaningful only while valid_o=1.
// CONFIGURATION
// - Macro DEC_ACCUM_ROUND_EN.
// - Defined: the first FRAC digit >=5 sets round flag; later FRAC digits are ignored.
//   - On entering DONE, acc <= acc+1 if round flag is set.
//   - If acc is already all-ones, acc is unchanged and ovf <= 1.
// - Undefined: truncation; all FRAC digits are discarded and there is no round flag register.
// STRUCTURE
// - Package dec_accum_pkg holds:
//   - typedef enum logic [1:0] {ACC, FRAC, DONE} dec_state_e
//   - DIGIT_MAX = 4'd9
//   - ROUND_THRESH = 4'd5
// - Sub-module dec_mac10 (combinational) computes a saturating acc*10+d as (acc<<3)+(acc<<1)+d.
//   - Outputs: next value and sat flag.
//   - Parameterised by WIDTH_P.
// - Top level holds the FSM, registers, handshake and the optional rounding increment.
// TESTING
// - Digits 1,2,3 then last, ready_i=1: valid_o at last+1 cycle; value_o=123, ovf_o=0, err_o=0.
// - Digits 1,2, point, 7, then last:
//   - DEC_ACCUM_ROUND_EN defined: value_o=13.
//   - Undefined: value_o=12.
// - Digits 3,0,0 then last (WIDTH_P=8): value_o=255, ovf_o=1.
//   - Digits 2,5,5 then last: value_o=255, ovf_o=0.
// - Digits 4, 4'hA, 2 then last: value_o=42, err_o=1.
//   - Separate field 1, point, point, last: value_o=1, err_o=1.
// - Backpressure: ready_i=0 for 5 cycles after the result.
//   - valid_o stays 1, ready_o stays 0, value_o stays stable.
//   - valid_i beats are not accepted.
// - Reset mid-field: digits 9,9 then reset_i=1 for one cycle, then digit 5 and last: value_o=5, no flags.

Source files
------------

// File: rtl/dec_accum_pkg.sv
// dec_accum_pkg: shared FSM state type and digit constants for the decimal accumulator.
package dec_accum_pkg;
  typedef enum logic [1:0] {ACC, FRAC, DONE} dec_state_e;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;
  localparam logic [3:0] ROUND_THRESH = 4'd5;
endpackage

// File: rtl/dec_accum_mac10.sv
// dec_mac10: combinational saturating acc*10+d, built from shifts and adds.
module dec_mac10 #(
  parameter int WIDTH_P = 8
) (
  input  logic [WIDTH_P-1:0] acc_i,
  input  logic [3:0]         digit_i,
  output logic [WIDTH_P-1:0] sum_o,
  output logic               sat_o
);
  logic [WIDTH_P+3:0] full;
  // Four guard bits hold (2**W-1)*10+9 without wrapping.
  assign full  = ({4'b0, acc_i} << 3) + ({4'b0, acc_i} << 1) + {{WIDTH_P{1'b0}}, digit_i};
  assign sat_o = |full[WIDTH_P+3:WIDTH_P];
  assign sum_o = sat_o ? '1 : full[WIDTH_P-1:0];
endmodule

// File: rtl/dec_accum.sv
// dec_accum: streaming MSD-first decimal-to-binary accumulator with saturation and error flags.
// Define DEC_ACCUM_ROUND_EN to round on the first fractional digit instead of truncating.
module dec_accum
  import dec_accum_pkg::*;
#(
  parameter int WIDTH_P = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [3:0]         digit_i,
  input  logic               point_i,
  input  logic               last_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [WIDTH_P-1:0] value_o,
  output logic               ovf_o,
  output logic               err_o,
  output logic               valid_o,
  input  logic               ready_i
);
  dec_state_e         state_q, state_d;
  logic [WIDTH_P-1:0] acc_q, acc_d, mac_sum;
  logic               ovf_q, ovf_d, err_q, err_d, mac_sat;
`ifdef DEC_ACCUM_ROUND_EN
  logic               round_q, round_d, seen_q, seen_d;
`endif

  dec_mac10 #(.WIDTH_P(WIDTH_P)) u_mac (
    .acc_i  (acc_q),
    .digit_i(digit_i),
    .sum_o  (mac_sum),
    .sat_o  (mac_sat)
  );

  assign ready_o = state_q != DONE;
  assign valid_o = state_q == DONE;
  assign value_o = acc_q;
  assign ovf_o   = ovf_q;
  assign err_o   = err_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
`ifdef DEC_ACCUM_ROUND_EN
    round_d = round_q;
    seen_d  = seen_q;
`endif
    if (state_q == DONE) begin
      if (ready_i) begin
        state_d = ACC;
        acc_d   = '0;
        ovf_d   = 1'b0;
        err_d   = 1'b0;
`ifdef DEC_ACCUM_ROUND_EN
        round_d = 1'b0;
        seen_d  = 1'b0;
`endif
      end
    end else if (valid_i) begin
      if (last_i) begin
        state_d = DONE;
`ifdef DEC_ACCUM_ROUND_EN
        if (round_q) begin
          acc_d = &acc_q ? acc_q : acc_q + 1'b1;
          ovf_d = ovf_q | (&acc_q);
        end
`endif
      end else if (point_i) begin
        err_d   = err_q | (state_q == FRAC);
        state_d = FRAC;
      end else if (digit_i > DIGIT_MAX) begin
        err_d = 1'b1;
      end else if (state_q == ACC) begin
        acc_d = mac_sum;
        ovf_d = ovf_q | mac_sat;
      end
`ifdef DEC_ACCUM_ROUND_EN
      else if (!seen_q) begin
        seen_d  = 1'b1;
        round_d = digit_i >= ROUND_THRESH;
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ACC;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef DEC_ACCUM_ROUND_EN
      round_q <= 1'b0;
      seen_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
`ifdef DEC_ACCUM_ROUND_EN
      round_q <= round_d;
      seen_q  <= seen_d;
`endif
    end
  end
endmodule

// File: tb/tb_dec_accum.sv
// tb_dec_accum: table-driven field vectors plus backpressure and mid-field reset sequences.
module tb_dec_accum;
  localparam logic [5:0] P  = 6'h10;
  localparam logic [5:0] L  = 6'h20;
  localparam logic [5:0] PL = 6'h30;
  typedef struct {
    string      name;
    logic [5:0] b[8];
    int         n;
    logic [7:0] val;
    logic       ovf;
    logic       err;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic [3:0] digit_i = '0;
  logic       point_i = 1'b0, last_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
  logic       ready_o, ovf_o, err_o, valid_o;
  logic [7:0] value_o;
  int         checks = 0, errors = 0;
  vec_t       v[13];

  dec_accum #(.WIDTH_P(8)) dut (
    .clk_i(clk), .reset_i(reset_i), .digit_i(digit_i), .point_i(point_i), .last_i(last_i),
    .valid_i(valid_i), .ready_o(ready_o), .value_o(value_o), .ovf_o(ovf_o), .err_o(err_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic beat(input logic [5:0] c);
    @(negedge clk);
    {last_i, point_i, digit_i} = c;
    valid_i = 1'b1;
    chk("ready_before_beat", ready_o, 1);
    @(posedge clk);
    #1 valid_i = 1'b0;
  endtask

  task automatic result(input string name, input logic [7:0] val, input logic ovf, input logic err);
    chk({name, "_valid"}, valid_o, 1);
    chk({name, "_value"}, value_o, val);
    chk({name, "_ovf"}, ovf_o, ovf);
    chk({name, "_err"}, err_o, err);
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk);
    #1 ready_i = 1'b0;
    chk({name, "_valid_clr"}, valid_o, 0);
    chk({name, "_ready_back"}, ready_o, 1);
  endtask

  initial begin
    v[0]  = '{"d123",     '{6'd1, 6'd2, 6'd3, L, 0, 0, 0, 0}, 4, 8'd123, 0, 0};
`ifdef DEC_ACCUM_ROUND_EN
    v[1]  = '{"d12p7",    '{6'd1, 6'd2, P, 6'd7, L, 0, 0, 0}, 5, 8'd13, 0, 0};
    v[2]  = '{"d255p9",   '{6'd2, 6'd5, 6'd5, P, 6'd9, L, 0, 0}, 6, 8'd255, 1, 0};
    v[3]  = '{"d25p6",    '{6'd2, 6'd5, P, 6'd6, L, 0, 0, 0}, 5, 8'd26, 0, 0};
`else
    v[1]  = '{"d12p7",    '{6'd1, 6'd2, P, 6'd7, L, 0, 0, 0}, 5, 8'd12, 0, 0};
    v[2]  = '{"d255p9",   '{6'd2, 6'd5, 6'd5, P, 6'd9, L, 0, 0}, 6, 8'd255, 0, 0};
    v[3]  = '{"d25p6",    '{6'd2, 6'd5, P, 6'd6, L, 0, 0, 0}, 5, 8'd25, 0, 0};
`endif
    v[4]  = '{"d300",     '{6'd3, 6'd0, 6'd0, L, 0, 0, 0, 0}, 4, 8'd255, 1, 0};
    v[5]  = '{"d255",     '{6'd2, 6'd5, 6'd5, L, 0, 0, 0, 0}, 4, 8'd255, 0, 0};
    v[6]  = '{"d4A2",     '{6'd4, 6'hA, 6'd2, L, 0, 0, 0, 0}, 4, 8'd42, 0, 1};
    v[7]  = '{"d1pp",     '{6'd1, P, P, L, 0, 0, 0, 0}, 4, 8'd1, 0, 1};
    v[8]  = '{"empty",    '{L, 0, 0, 0, 0, 0, 0, 0}, 1, 8'd0, 0, 0};
    v[9]  = '{"pt_last",  '{6'd5, PL, 0, 0, 0, 0, 0, 0}, 2, 8'd5, 0, 0};
    v[10] = '{"d3000",    '{6'd3, 6'd0, 6'd0, 6'd0, 6'd7, L, 0, 0}, 6, 8'd255, 1, 0};
    v[11] = '{"d1p38",    '{6'd1, P, 6'd3, 6'd8, L, 0, 0, 0}, 5, 8'd1, 0, 0};
    v[12] = '{"last_dig", '{6'd7, 6'h27, 6'd9, 6'h2F, 6'd3, L, 0, 0}, 2, 8'd7, 0, 0};

    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    chk("rst_value", value_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_ready", ready_o, 1);

    for (int i = 0; i < 13; i++) begin
      for (int j = 0; j < v[i].n; j++) beat(v[i].b[j]);
      result(v[i].name, v[i].val, v[i].ovf, v[i].err);
    end

    beat(6'd1); beat(6'd2); beat(6'd3); beat(L);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      {last_i, point_i, digit_i} = (k % 2) ? L : 6'd9;
      valid_i = 1'b1;
      chk("bp_valid", valid_o, 1);
      chk("bp_ready", ready_o, 0);
      chk("bp_value", value_o, 123);
    end
    @(negedge clk);
    valid_i = 1'b0;
    result("bp_end", 8'd123, 0, 0);

    beat(6'd9); beat(6'd9);
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    chk("midrst_value", value_o, 0);
    chk("midrst_valid", valid_o, 0);
    chk("midrst_ready", ready_o, 1);
    beat(6'd5); beat(L);
    result("midrst", 8'd5, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
